// File: rtl/serial_bcd_sequencer.sv
// Digit-serial BCD add sequencer: streams operand digit pairs to an external
// combinational BCD digit adder and collects the sum, plus the final carry, into one packed result.
module serial_bcd_sequencer #(
   parameter int unsigned NUM_DIGITS = 4
) (
   input  logic                        clk,
   input  logic                        rstn,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [4*NUM_DIGITS-1:0]     op_a,
   input  logic [4*NUM_DIGITS-1:0]     op_b,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [4*(NUM_DIGITS+1)-1:0] result,
   output logic                        bcd_err,
   output logic [3:0]                  ser_a,
   output logic [3:0]                  ser_b,
   output logic                        ser_start,
   output logic                        ser_done,
   input  logic [3:0]                  ser_sum
);

   localparam int unsigned DW = 4 * NUM_DIGITS;
   localparam int unsigned RW = 4 * (NUM_DIGITS + 1);
   localparam int unsigned CW = $clog2(NUM_DIGITS) + 1;

   typedef enum logic [1:0] {IDLE, SEND, FLUSH, HOLD} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q;
   logic [DW-1:0]   a_sh_q, b_sh_q;
   logic [RW-1:0]   result_q;
   logic            bcd_err_q;
   logic            in_ready_q, out_valid_q, ser_start_q, ser_done_q;
   logic            in_ready_d, out_valid_d, ser_start_d, ser_done_d;
   logic            accept;

   function automatic logic has_bad_digit(input logic [DW-1:0] v);
      logic bad;
      bad = 1'b0;
      for (int i = 0; i < int'(NUM_DIGITS); i++) begin
         if (v[4*i +: 4] > 4'd9) bad = 1'b1;
      end
      return bad;
   endfunction

   // State register plus registered handshake/framing outputs
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= IDLE;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         ser_start_q <= 1'b0;
         ser_done_q  <= 1'b1;
      end else begin
         state_q     <= state_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         ser_start_q <= ser_start_d;
         ser_done_q  <= ser_done_d;
      end
   end

   // Next state; outputs are decoded from the next state so they line up with it
   always_comb begin
      state_d     = state_q;
      accept      = 1'b0;
      in_ready_d  = 1'b0;
      out_valid_d = 1'b0;
      ser_start_d = 1'b0;
      ser_done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (in_valid && in_ready_q) begin
               accept  = 1'b1;
               state_d = SEND;
            end
         end
         SEND: begin
            if (cnt_q == CW'(NUM_DIGITS - 1)) state_d = FLUSH;
         end
         FLUSH: state_d = HOLD;
         HOLD: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      in_ready_d  = (state_d == IDLE);
      out_valid_d = (state_d == HOLD);
      ser_start_d = accept;
      ser_done_d  = (state_d == IDLE) || (state_d == HOLD);
   end

   // Datapath: operand shifters empty themselves to zero by FLUSH, keeping ser_a/ser_b at 0 outside SEND
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt_q     <= '0;
         a_sh_q    <= '0;
         b_sh_q    <= '0;
         result_q  <= '0;
         bcd_err_q <= 1'b0;
      end else if (accept) begin
         cnt_q     <= '0;
         a_sh_q    <= op_a;
         b_sh_q    <= op_b;
         result_q  <= '0;
         bcd_err_q <= has_bad_digit(op_a) | has_bad_digit(op_b);
      end else if (state_q == SEND || state_q == FLUSH) begin
         for (int i = 0; i <= int'(NUM_DIGITS); i++) begin
            if (cnt_q == CW'(i)) result_q[4*i +: 4] <= ser_sum;
         end
         if (state_q == SEND) begin
            cnt_q  <= cnt_q + CW'(1);
            a_sh_q <= a_sh_q >> 4;
            b_sh_q <= b_sh_q >> 4;
         end
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign ser_start = ser_start_q;
   assign ser_done  = ser_done_q;
   assign ser_a     = a_sh_q[3:0];
   assign ser_b     = b_sh_q[3:0];
   assign result    = result_q;
   assign bcd_err   = bcd_err_q;

endmodule
